// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting bursts from four requesters onto one FIFO write port.
// Latency: grant registered one cycle after valid in IDLE; write path combinational from owner.
// Backpressure: fifo_full drops owner's req_ready and fifo_wr, freezing beat count and state.
// Optional: define ARB_STALL_STATS_EN to build the saturating stall counter on stall_cnt.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ-1:0]    req_last,
   output logic [NREQ-1:0]    req_ready,
   input  logic               fifo_full,
   output logic               fifo_wr,
   output logic [DW-1:0]      fifo_din,
   output logic [NREQ-1:0]    grant,
   output logic               busy,
   output logic [15:0]        stall_cnt
);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t          r_state, w_state_nxt;
   logic [1:0]      r_owner, w_owner_nxt;
   logic [1:0]      r_last_grant, w_last_grant_nxt;
   logic [3:0]      r_beat_cnt, w_beat_cnt_nxt;
   logic [NREQ-1:0] r_grant, w_grant_nxt;
   logic [1:0]      w_pick;
   logic            w_any;

   // Round-robin search starting one past the previous owner; previous owner is checked last.
   always_comb begin
      logic [1:0] idx;
      w_any  = 1'b0;
      w_pick = r_last_grant;
      idx    = r_last_grant;
      for (int k = 1; k <= 4; k++) begin
         idx = r_last_grant + 2'(k);
         if (!w_any && req_valid[idx]) begin
            w_any  = 1'b1;
            w_pick = idx;
         end
      end
   end

   // Next-state and write-path outputs; write path is live only while a burst owns the port.
   always_comb begin
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_last_grant_nxt = r_last_grant;
      w_beat_cnt_nxt   = r_beat_cnt;
      w_grant_nxt      = r_grant;
      req_ready        = '0;
      fifo_wr          = 1'b0;
      fifo_din         = '0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt    = S_BURST;
               w_owner_nxt    = w_pick;
               w_grant_nxt    = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
               w_beat_cnt_nxt = 4'd0;
            end
         end
         S_BURST: begin
            req_ready[r_owner] = ~fifo_full;
            fifo_din           = req_data[r_owner*DW +: DW];
            fifo_wr            = req_valid[r_owner] & ~fifo_full;
            if (fifo_wr) begin
               w_beat_cnt_nxt = r_beat_cnt + 4'd1;
               // Packet end or burst cap hands the port back for re-arbitration.
               if (req_last[r_owner] || (r_beat_cnt + 4'd1) == 4'(MAX_BURST)) begin
                  w_state_nxt      = S_IDLE;
                  w_last_grant_nxt = r_owner;
                  w_grant_nxt      = '0;
                  w_beat_cnt_nxt   = 4'd0;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State registers; last_grant resets to 3 so requester 0 wins the first arbitration.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_owner      <= 2'd0;
         r_last_grant <= 2'd3;
         r_beat_cnt   <= 4'd0;
         r_grant      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_beat_cnt   <= w_beat_cnt_nxt;
         r_grant      <= w_grant_nxt;
      end
   end

   assign grant = r_grant;
   assign busy  = (r_state == S_BURST);

`ifdef ARB_STALL_STATS_EN
   logic [15:0] r_stall_cnt;

   // Count owner cycles blocked by a full FIFO, saturating at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= 16'd0;
      end else if (r_state == S_BURST && req_valid[r_owner] && fifo_full &&
                   r_stall_cnt != 16'hFFFF) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus random traffic against a reference model.
module tb_fifo_wr_arbiter;

   localparam int MAXB = 8;
`ifdef ARB_STALL_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '0;
   logic [3:0]  req_ready;
   logic        fifo_full = 1'b0;
   logic        fifo_wr;
   logic [7:0]  fifo_din;
   logic [3:0]  grant;
   logic        busy;
   logic [15:0] stall_cnt;

   fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
      .fifo_wr(fifo_wr), .fifo_din(fifo_din), .grant(grant), .busy(busy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: owner index (-1 when idle), beats in current burst, previous owner.
   int m_owner, m_beats, m_lastg, m_stall;
   logic       m_wr;
   logic [7:0] m_wr_dat;
   int         m_wr_own;
   int         g_log[$];
   int         len_log[$];
   logic [7:0] wq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_beats = 0; m_lastg = 3; m_stall = 0;
      g_log.delete(); len_log.delete(); wq.delete();
   endtask

   // One clock cycle: drive inputs at negedge, compare against model, advance model at posedge.
   task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic f);
      logic       eb, ew;
      logic [3:0] eg, er;
      logic [7:0] ed;
      req_valid = v; req_data = d; req_last = l; fifo_full = f;
      #1;
      eb = (m_owner >= 0);
      eg = eb ? 4'(1 << m_owner) : 4'b0;
      er = (eb && !f) ? eg : 4'b0;
      ew = eb ? (v[m_owner] && !f) : 1'b0;
      ed = eb ? d[8*m_owner +: 8] : 8'h00;
      chk("busy", {31'b0, busy}, {31'b0, eb});
      chk("grant", {28'b0, grant}, {28'b0, eg});
      chk("req_ready", {28'b0, req_ready}, {28'b0, er});
      chk("fifo_wr", {31'b0, fifo_wr}, {31'b0, ew});
      if (eb) chk("fifo_din", {24'b0, fifo_din}, {24'b0, ed});
      chk("stall_cnt", {16'b0, stall_cnt}, 32'(m_stall));
      m_wr = ew; m_wr_dat = ed; m_wr_own = m_owner;
      if (ew) wq.push_back(ed);
      @(posedge clk);
      if (m_owner < 0) begin
         if (v != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
               int c;
               c = (m_lastg + k) % 4;
               if (m_owner < 0 && v[c]) m_owner = c;
            end
            m_beats = 0;
            g_log.push_back(m_owner);
         end
      end else begin
         if (STATS != 0 && v[m_owner] && f && m_stall < 65535) m_stall++;
         if (ew) begin
            m_beats++;
            if (l[m_owner] || m_beats == MAXB) begin
               len_log.push_back(m_beats);
               m_lastg = m_owner;
               m_owner = -1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid = '0; req_last = '0; fifo_full = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_grant", {28'b0, grant}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_ready", {28'b0, req_ready}, 32'd0);
      chk("rst_wr", {31'b0, fifo_wr}, 32'd0);
      chk("rst_stall", {16'b0, stall_cnt}, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int sent;
      logic [31:0] d;
      logic [3:0]  v, l;
      model_reset();
      @(negedge clk);

      // Single requester, three-beat packet A1..A3.
      do_reset();
      sent = 0;
      for (int c = 0; c < 8; c++) begin
         cycle((sent < 3) ? 4'b0001 : 4'b0000, {24'h0, 8'(8'hA1 + sent)},
               (sent == 2) ? 4'b0001 : 4'b0000, 1'b0);
         if (m_wr) sent++;
      end
      chk("single_nwr", 32'(wq.size()), 32'd3);
      chk("single_d0", {24'b0, (wq.size() > 0) ? wq[0] : 8'h00}, 32'hA1);
      chk("single_d1", {24'b0, (wq.size() > 1) ? wq[1] : 8'h00}, 32'hA2);
      chk("single_d2", {24'b0, (wq.size() > 2) ? wq[2] : 8'h00}, 32'hA3);
      chk("single_len", 32'(qget(len_log, 0)), 32'd3);

      // All four valid with last on every beat: order 0,1,2,3,0.
      do_reset();
      for (int c = 0; c < 12; c++) cycle(4'b1111, 32'h44332211, 4'b1111, 1'b0);
      for (int i = 0; i < 5; i++) chk("rr_order", 32'(qget(g_log, i)), 32'(i % 4));

      // Requester 2 streams 20 beats without last: capped at MAX_BURST.
      do_reset();
      sent = 0;
      for (int c = 0; c < 30; c++) begin
         cycle((sent < 20) ? 4'b0100 : 4'b0000, {8'h0, 8'(sent), 16'h0}, 4'b0000, 1'b0);
         if (m_wr) sent++;
      end
      chk("cap_len0", 32'(qget(len_log, 0)), 32'd8);
      chk("cap_len1", 32'(qget(len_log, 1)), 32'd8);
      chk("cap_own0", 32'(qget(g_log, 0)), 32'd2);
      chk("cap_own1", 32'(qget(g_log, 1)), 32'd2);

      // FIFO full for 5 cycles in the middle of a burst from requester 1.
      do_reset();
      sent = 0;
      for (int c = 0; c < 16; c++) begin
         cycle((sent < 8) ? 4'b0010 : 4'b0000, {16'h0, 8'(8'h70 + sent), 8'h0}, 4'b0000,
               (c >= 3 && c < 8));
         if (m_wr) sent++;
      end
      chk("full_len", 32'(qget(len_log, 0)), 32'd8);
      chk("full_stall", {16'b0, stall_cnt}, (STATS != 0) ? 32'd5 : 32'd0);

      // Asynchronous reset during beat 2.
      do_reset();
      cycle(4'b0001, 32'h000000C1, 4'b0000, 1'b0);
      cycle(4'b0001, 32'h000000C1, 4'b0000, 1'b0);
      req_valid = 4'b0011; req_data = 32'h0000D2C2; req_last = 4'b0000;
      #2;
      chk("pre_async_busy", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("async_grant", {28'b0, grant}, 32'd0);
      chk("async_busy", {31'b0, busy}, 32'd0);
      chk("async_wr", {31'b0, fifo_wr}, 32'd0);
      chk("async_ready", {28'b0, req_ready}, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) cycle(4'b1111, 32'h44332211, 4'b1111, 1'b0);
      chk("post_rst_win", 32'(qget(g_log, 0)), 32'd0);

      // Owner's valid drops for two cycles while requester 1 waits.
      do_reset();
      sent = 0;
      for (int c = 0; c < 16; c++) begin
         v = {3'b001, (sent < 5 && c != 3 && c != 4)};
         l = {3'b001, (sent == 4)};
         d = {16'h0, 8'h51, 8'(8'h30 + sent)};
         cycle(v, d, l, 1'b0);
         if (m_wr && m_wr_own == 0) sent++;
      end
      chk("hold_own0", 32'(qget(g_log, 0)), 32'd0);
      chk("hold_len0", 32'(qget(len_log, 0)), 32'd5);
      chk("hold_own1", 32'(qget(g_log, 1)), 32'd1);

      // Random traffic checked cycle by cycle against the model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         v = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) l[i] = ($urandom_range(0, 9) < 3);
         cycle(v, $urandom, l, ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters (fixed at 4; other values are not supported).
REQ-002 The block SHALL have parameter DW, default 8, data width, matching the 8-bit FIFO write port.
REQ-003 The block SHALL have parameter MAX_BURST, default 8, the maximum beats per grant (range 1..15).
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  4  per-requester data-valid.
REQ-007 req_data  input  32  requester i data on bits [8i+7:8i].
REQ-008 req_last  input  4  per-requester end-of-packet marker, qualified by valid.
REQ-009 req_ready  output  4  per-requester accept.
REQ-010 fifo_full  input  1  FIFO full status.
REQ-011 fifo_wr  output  1  FIFO write request.
REQ-012 fifo_din  output  8  FIFO write data.
REQ-013 grant  output  4  registered one-hot owner; 0 when idle.
REQ-014 busy  output  1  high while in BURST.
REQ-015 stall_cnt  output  16  stall statistic (see Configuration).

Function
REQ-016 The FSM SHALL have two states: IDLE and BURST.
REQ-017 In IDLE with any req_valid set, the block SHALL select the first valid requester in round-robin order starting at last_grant+1 (mod 4), load grant, clear beat_cnt, and enter BURST on the next edge.
REQ-018 In IDLE, req_ready SHALL be 0, fifo_wr SHALL be 0, and busy SHALL be 0.
REQ-019 In BURST with owner g, req_ready[g] SHALL equal ~fifo_full, and all other req_ready bits SHALL be 0.
REQ-020 In BURST, fifo_wr SHALL be req_valid[g] & ~fifo_full (combinational), and fifo_din SHALL be req_data[8g+7:8g].
REQ-021 A beat is a cycle with fifo_wr=1; each beat SHALL increment the 4-bit beat_cnt.
REQ-022 BURST SHALL exit to IDLE on the edge after a beat with req_last[g]=1, or after a beat that makes beat_cnt equal MAX_BURST; on exit, last_grant SHALL become g and grant SHALL become 0.
REQ-023 Valid deasserting mid-burst SHALL NOT end the burst; the owner SHALL hold the grant until last or MAX_BURST.
REQ-024 When fifo_full=1 in BURST, no beat SHALL occur, and the state and beat_cnt SHALL hold.
REQ-025 Latency: valid in IDLE at cycle n SHALL give grant at n+1, with the first beat possible at n+1; each re-arbitration SHALL cost exactly one IDLE bubble cycle.
REQ-026 No requester SHALL wait more than 3 bursts while its valid is held high (starvation bound).
REQ-027 Requests arriving in the same cycle SHALL be resolved solely by the round-robin order.

Reset
REQ-028 While reset=0, the block SHALL set state=IDLE, grant=0, beat_cnt=0, last_grant=3 (so requester 0 wins first), and stall_cnt=0.
REQ-029 On reset asserted mid-burst, all outputs SHALL go to idle values immediately, without waiting for a clock edge.
REQ-030 Reset deassertion SHALL be synchronized externally; the block's first arbitration SHALL occur on the first edge after release.

Configuration
REQ-031 With macro ARB_STALL_STATS_EN defined, stall_cnt SHALL increment on each BURST cycle where req_valid[g]=1 and fifo_full=1, saturating at 16'hFFFF.
REQ-032 With ARB_STALL_STATS_EN undefined, stall_cnt SHALL be constant 0, no counter logic SHALL be present, and all other behaviour SHALL be identical.

Verification
REQ-033 Single requester: req 0 sends 3 beats with last on beat 3 (data 8'hA1..A3) -> grant=0001 one cycle after valid, 3 writes, then IDLE; fifo sees A1,A2,A3.
REQ-034 All four requesters valid continuously with last on every beat, after reset -> grant order 0,1,2,3,0 with one bubble between each.
REQ-035 Req 2 streams 20 beats with no last -> grant is released after exactly 8 beats, then re-acquired by 2 (if alone) after 1 bubble.
REQ-036 fifo_full held high for 5 cycles mid-burst -> no fifo_wr, req_ready[g]=0, beat_cnt frozen, and stall_cnt +5 when ARB_STALL_STATS_EN is defined, 0 otherwise.
REQ-037 reset pulled low during beat 2 of a burst -> grant=0 and busy=0 asynchronously; after release, req 0 wins the first arbitration.
REQ-038 Owner's valid drops for 2 cycles mid-burst while req 1 is valid -> the grant stays with the owner until its last beat.
